// File: rtl/beep_seq_if.sv
// Event-code / buzzer bundle between the upstream event source and beep_seq.
// master drives the event code; slave (the sequencer) drives the buzzer pin and busy.
interface beep_seq_if #(
    parameter int unsigned CODE_W = 8
);
    logic [CODE_W-1:0] key;
    logic              beep_pin;
    logic              busy;

    modport master (
        output key,
        input  beep_pin,
        input  busy
    );

    modport slave (
        input  key,
        output beep_pin,
        output busy
    );
endinterface

// File: rtl/beep_seq.sv
// Buzzer sequencer: event code N plays N square-wave bursts separated by silent gaps.
// A code only fires after key has been seen at 0 (armed); codes arriving while busy are dropped.
module beep_seq #(
    parameter int unsigned CODE_W    = 8,
    parameter int unsigned MAX_CODE  = 9,
    parameter int unsigned TONE_HALF = 40000,
    parameter int unsigned ON_CYC    = 12500000,
    parameter int unsigned OFF_CYC   = 12500000
) (
    input  logic      clk,
    input  logic      rst_n,
    beep_seq_if.slave bus
);

    localparam int unsigned REM_W   = $clog2(MAX_CODE + 1);
    localparam int unsigned DUR_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int unsigned DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
    localparam int unsigned TONE_W  = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    localparam logic [CODE_W-1:0] KEY_MAX   = CODE_W'(MAX_CODE);
    localparam logic [DUR_W-1:0]  ON_LAST   = DUR_W'(ON_CYC - 1);
    localparam logic [DUR_W-1:0]  OFF_LAST  = DUR_W'(OFF_CYC - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
    localparam logic [REM_W-1:0]  REM_ONE   = REM_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StTone,
        StGap
    } state_e;

    state_e              r_state;
    logic                r_armed;
    logic [REM_W-1:0]    r_remaining;
    logic [DUR_W-1:0]    r_dur_cnt;
    logic [TONE_W-1:0]   r_tone_cnt;
    logic                r_beep;
    logic                r_busy;

    state_e              w_state_nxt;
    logic                w_armed_nxt;
    logic [REM_W-1:0]    w_remaining_nxt;
    logic [DUR_W-1:0]    w_dur_cnt_nxt;
    logic [TONE_W-1:0]   w_tone_cnt_nxt;
    logic                w_beep_nxt;

    logic [CODE_W-1:0]   w_key;
    logic                w_key_zero;
    logic                w_key_valid;
    logic                w_fire;

    assign w_key       = bus.key;
    assign w_key_zero  = (w_key == '0);
    assign w_key_valid = !w_key_zero && (w_key <= KEY_MAX);
    assign w_fire      = (r_state == StIdle) && r_armed && w_key_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_armed     <= 1'b0;
            r_remaining <= '0;
            r_dur_cnt   <= '0;
            r_tone_cnt  <= '0;
            r_beep      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_armed     <= w_armed_nxt;
            r_remaining <= w_remaining_nxt;
            r_dur_cnt   <= w_dur_cnt_nxt;
            r_tone_cnt  <= w_tone_cnt_nxt;
            r_beep      <= w_beep_nxt;
            r_busy      <= (w_state_nxt != StIdle);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_dur_cnt_nxt   = r_dur_cnt;
        w_tone_cnt_nxt  = r_tone_cnt;
        w_beep_nxt      = 1'b0;
        // Arming follows key==0 in every state; only an accepted trigger disarms.
        w_armed_nxt     = r_armed | w_key_zero;

        unique case (r_state)
            StIdle: begin
                w_dur_cnt_nxt  = '0;
                w_tone_cnt_nxt = '0;
                if (w_fire) begin
                    w_remaining_nxt = w_key[REM_W-1:0];
                    w_armed_nxt     = 1'b0;
                    w_state_nxt     = StTone;
                end
            end

            StTone: begin
                if (r_dur_cnt == ON_LAST) begin
                    w_dur_cnt_nxt  = '0;
                    w_tone_cnt_nxt = '0;
                    if (r_remaining == REM_ONE) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_remaining_nxt = r_remaining - REM_ONE;
                        w_state_nxt     = StGap;
                    end
                end else begin
                    w_dur_cnt_nxt = r_dur_cnt + 1'b1;
                    if (r_tone_cnt == TONE_LAST) begin
                        w_tone_cnt_nxt = '0;
                        w_beep_nxt     = ~r_beep;
                    end else begin
                        w_tone_cnt_nxt = r_tone_cnt + 1'b1;
                        w_beep_nxt     = r_beep;
                    end
                end
            end

            StGap: begin
                w_tone_cnt_nxt = '0;
                if (r_dur_cnt == OFF_LAST) begin
                    w_dur_cnt_nxt = '0;
                    w_state_nxt   = StTone;
                end else begin
                    w_dur_cnt_nxt = r_dur_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt    = StIdle;
                w_dur_cnt_nxt  = '0;
                w_tone_cnt_nxt = '0;
            end
        endcase
    end

    assign bus.beep_pin = r_beep;
    assign bus.busy     = r_busy;

    // The buzzer may only sound while a sequence is in flight.
    a_beep_implies_busy : assert property (
        @(posedge clk) disable iff (!rst_n) r_beep |-> r_busy
    );

    a_remaining_nonzero : assert property (
        @(posedge clk) disable iff (!rst_n) (r_state != StIdle) |-> (r_remaining != '0)
    );

endmodule

// File: tb/tb_beep_seq.sv
// Bench for beep_seq: directed scenarios plus random key traffic, each cycle compared
// against a timeline model (trigger edge + code -> expected busy/beep by arithmetic).
module tb_beep_seq;

    localparam int unsigned CODE_W    = 8;
    localparam int unsigned MAX_CODE  = 9;
    localparam int unsigned TONE_HALF = 4;
    localparam int unsigned ON_CYC    = 20;
    localparam int unsigned OFF_CYC   = 10;

    logic clk;
    logic rst_n;

    beep_seq_if #(.CODE_W(CODE_W)) u_if ();

    beep_seq #(
        .CODE_W    (CODE_W),
        .MAX_CODE  (MAX_CODE),
        .TONE_HALF (TONE_HALF),
        .ON_CYC    (ON_CYC),
        .OFF_CYC   (OFF_CYC)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Model: a sequence is fully described by the edge it was accepted on and its code.
    int m_cyc;
    int m_k;
    int m_n;
    bit m_active;
    bit m_armed;

    int acc_busy;
    int acc_beep;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int seq_len(input int n);
        return n * ON_CYC + (n - 1) * OFF_CYC;
    endfunction

    function automatic int exp_busy();
        if (!m_active) return 0;
        return ((m_cyc - m_k) < seq_len(m_n)) ? 1 : 0;
    endfunction

    function automatic int exp_beep();
        int t;
        int p;
        if (exp_busy() == 0) return 0;
        t = m_cyc - m_k;
        p = t % (ON_CYC + OFF_CYC);
        if (p >= ON_CYC) return 0;
        return ((p / TONE_HALF) % 2 == 1) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_armed  = 1'b0;
    endtask

    // Model update for one rising edge that samples key value kv.
    task automatic model_edge(input int kv);
        bit idle_before;
        m_cyc++;
        idle_before = !m_active || ((m_cyc - 1 - m_k) >= seq_len(m_n));
        if (idle_before && m_armed && kv >= 1 && kv <= MAX_CODE) begin
            m_active = 1'b1;
            m_k      = m_cyc;
            m_n      = kv;
            m_armed  = 1'b0;
        end
        if (kv == 0) m_armed = 1'b1;
    endtask

    // Called at a falling edge: drive key, take one rising edge, check at the next falling edge.
    task automatic step(input int kv);
        u_if.key = CODE_W'(kv);
        @(posedge clk);
        model_edge(kv);
        @(negedge clk);
        check_eq("busy", int'(u_if.busy), exp_busy());
        check_eq("beep_pin", int'(u_if.beep_pin), exp_beep());
        acc_busy += int'(u_if.busy);
        acc_beep += int'(u_if.beep_pin);
    endtask

    task automatic step_n(input int kv, input int n);
        for (int i = 0; i < n; i++) step(kv);
    endtask

    task automatic clear_acc();
        acc_busy = 0;
        acc_beep = 0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop without a clock edge.
    task automatic do_reset(input int kv_hold);
        u_if.key = CODE_W'(kv_hold);
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", int'(u_if.busy), 0);
        check_eq("rst_beep", int'(u_if.beep_pin), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int kv;
        int hold;
        n_cmp    = 0;
        n_bad    = 0;
        m_cyc    = 0;
        m_k      = 0;
        m_n      = 1;
        u_if.key = '0;
        rst_n    = 1'b0;
        model_reset();
        clear_acc();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("por_busy", int'(u_if.busy), 0);
        check_eq("por_beep", int'(u_if.beep_pin), 0);
        rst_n = 1'b1;

        // Code 3: 80 busy cycles, 8 high cycles per burst.
        step_n(0, 2);
        clear_acc();
        step(3);
        step_n(0, 100);
        check_eq("t1_busy_len", acc_busy, 80);
        check_eq("t1_beep_high", acc_beep, 24);

        // Code 1: single burst, no gap.
        clear_acc();
        step(1);
        step_n(0, 40);
        check_eq("t2_busy_len", acc_busy, 20);
        check_eq("t2_beep_high", acc_beep, 8);

        // Code above MAX_CODE is ignored.
        clear_acc();
        step_n(10, 3);
        step_n(0, 5);
        check_eq("t3_busy_len", acc_busy, 0);
        check_eq("t3_beep_high", acc_beep, 0);

        // Held key fires once; release and re-press fires again.
        clear_acc();
        step_n(2, 200);
        check_eq("t4_held_busy", acc_busy, 50);
        step_n(0, 5);
        clear_acc();
        step(2);
        step_n(0, 60);
        check_eq("t4_retrig_busy", acc_busy, 50);

        // New code while busy does not restart or extend.
        clear_acc();
        step(5);
        step_n(0, 28);
        step_n(7, 20);
        step_n(0, 150);
        check_eq("t5_busy_len", acc_busy, 140);

        // Reset mid-TONE, then a held code must not fire until re-armed.
        step(4);
        step_n(4, 24);
        do_reset(4);
        clear_acc();
        step_n(4, 20);
        check_eq("t6_no_fire", acc_busy, 0);
        step(0);
        clear_acc();
        step(4);
        step_n(0, 120);
        check_eq("t6_rearm_busy", acc_busy, 110);

        // Random traffic: mostly idle key with bursts of valid/invalid codes and rare resets.
        for (int seg = 0; seg < 200; seg++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset(int'($urandom_range(0, 12)));
            end
            if ($urandom_range(0, 9) < 5) kv = 0;
            else kv = int'($urandom_range(0, 12));
            hold = int'($urandom_range(1, 40));
            step_n(kv, hold);
        end
        step_n(0, 400);
        check_eq("final_idle", int'(u_if.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
